// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing one single-port memory interface among NREQ requesters.
// Optional burst hold (up to MAX_HOLD beats per owner) is enabled by defining MEM_ARB_BURST_HOLD_EN.
module mem_port_arb #(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            s_cs,
    input  logic [NREQ-1:0]            s_we,
    input  logic [NREQ*ADDR_W-1:0]     s_addr,
    input  logic [NREQ*DATA_W/8-1:0]   s_byte,
    input  logic [NREQ*DATA_W-1:0]     s_di,
    output logic [NREQ-1:0]            s_busy,
    output logic [DATA_W-1:0]          s_do,
    output logic [NREQ-1:0]            s_rvalid,
    output logic                       m_cs,
    output logic                       m_we,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [DATA_W/8-1:0]        m_byte,
    output logic [DATA_W-1:0]          m_di,
    input  logic [DATA_W-1:0]          m_do,
    input  logic                       m_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = DATA_W / 8;

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] rd_owner_q;
    logic          hold_q;
    logic          rd_pend_q;

    logic [IW-1:0] gnt;
    logic [IW-1:0] rr_gnt;
    logic [IW-1:0] cand;
    logic          found;
    logic          req;
    logic          accept;

    assign req    = |s_cs;
    assign accept = m_cs & ~m_busy;
    assign s_do   = m_do;

    // Rotating search starting just after the last granted requester.
    always_comb begin
        rr_gnt = ptr;
        cand   = ptr;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && s_cs[cand]) begin
                rr_gnt = cand;
                found  = 1'b1;
            end
        end
    end

`ifdef MEM_ARB_BURST_HOLD_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] beat_cnt;
    logic          burst_keep;

    assign burst_keep = (beat_cnt != '0) && (beat_cnt < CW'(MAX_HOLD)) && s_cs[ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt <= '0;
        end else if (accept) begin
            if (gnt != ptr) begin
                beat_cnt <= CW'(1);
            end else if (beat_cnt < CW'(MAX_HOLD)) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
`endif

    // A stalled grant only sticks while its owner keeps cs asserted.
    always_comb begin
        gnt = rr_gnt;
        if (hold_q && s_cs[gnt_q]) begin
            gnt = gnt_q;
        end
`ifdef MEM_ARB_BURST_HOLD_EN
        else if (burst_keep) begin
            gnt = ptr;
        end
`endif
    end

    always_comb begin
        m_cs   = req;
        m_we   = 1'b0;
        m_addr = '0;
        m_byte = '0;
        m_di   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req && (IW'(i) == gnt)) begin
                m_we   = s_we[i];
                m_addr = s_addr[i*ADDR_W +: ADDR_W];
                m_byte = s_byte[i*BW +: BW];
                m_di   = s_di[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        s_busy   = '0;
        s_rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            s_busy[i]   = s_cs[i] & ~((IW'(i) == gnt) & ~m_busy);
            s_rvalid[i] = rd_pend_q & (IW'(i) == rd_owner_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr        <= IW'(NREQ - 1);
            gnt_q      <= '0;
            hold_q     <= 1'b0;
            rd_owner_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            hold_q    <= m_cs & m_busy;
            rd_pend_q <= accept & ~m_we;
            if (m_cs & m_busy) begin
                gnt_q <= gnt;
            end
            if (accept) begin
                ptr <= gnt;
            end
            if (accept & ~m_we) begin
                rd_owner_q <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb (NREQ=2): vector table, reset corner case,
// and randomized traffic against a rule-level reference model.
module tb_mem_port_arb;

    logic        clk;
    logic        rstn;
    logic [1:0]  s_cs;
    logic [1:0]  s_we;
    logic [63:0] s_addr;
    logic [7:0]  s_byte;
    logic [63:0] s_di;
    logic [1:0]  s_busy;
    logic [31:0] s_do;
    logic [1:0]  s_rvalid;
    logic        m_cs;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_byte;
    logic [31:0] m_di;
    logic [31:0] m_do;
    logic        m_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  cs;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [3:0]  b1;
        logic        busy;
        logic [31:0] mdo;
        logic        e_cs;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_di;
        logic [3:0]  e_byte;
        logic [1:0]  e_sbusy;
        logic [1:0]  e_rv;
    } vec_t;

    vec_t vecs[$];

    mem_port_arb #(.NREQ(2), .ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_cs     (s_cs),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_byte   (s_byte),
        .s_di     (s_di),
        .s_busy   (s_busy),
        .s_do     (s_do),
        .s_rvalid (s_rvalid),
        .m_cs     (m_cs),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_byte   (m_byte),
        .m_di     (m_di),
        .m_do     (m_do),
        .m_busy   (m_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic e_cs, input logic e_we,
                             input logic [31:0] e_addr, input logic [31:0] e_di,
                             input logic [3:0] e_byte, input logic [1:0] e_sb,
                             input logic [1:0] e_rv, input logic [31:0] e_do);
        check_output({tag, ".m_cs"},     64'(m_cs),     64'(e_cs));
        check_output({tag, ".m_we"},     64'(m_we),     64'(e_we));
        check_output({tag, ".m_addr"},   64'(m_addr),   64'(e_addr));
        check_output({tag, ".m_di"},     64'(m_di),     64'(e_di));
        check_output({tag, ".m_byte"},   64'(m_byte),   64'(e_byte));
        check_output({tag, ".s_busy"},   64'(s_busy),   64'(e_sb));
        check_output({tag, ".s_rvalid"}, 64'(s_rvalid), 64'(e_rv));
        check_output({tag, ".s_do"},     64'(s_do),     64'(e_do));
    endtask

    task automatic apply_stimulus(input logic [1:0] cs, input logic [1:0] we,
                                  input logic [31:0] a0, input logic [31:0] a1,
                                  input logic [31:0] d0, input logic [31:0] d1,
                                  input logic [3:0] b0, input logic [3:0] b1,
                                  input logic busy, input logic [31:0] mdo);
        s_cs   = cs;
        s_we   = we;
        s_addr = {a1, a0};
        s_di   = {d1, d0};
        s_byte = {b1, b0};
        m_busy = busy;
        m_do   = mdo;
    endtask

    task automatic add_vec(input logic [1:0] cs, input logic [1:0] we, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] b1,
                           input logic busy, input logic [31:0] mdo, input logic e_cs,
                           input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_di,
                           input logic [3:0] e_byte, input logic [1:0] e_sbusy, input logic [1:0] e_rv);
        vec_t v;
        v.cs = cs; v.we = we; v.a0 = a0; v.a1 = a1; v.d1 = d1; v.b1 = b1;
        v.busy = busy; v.mdo = mdo; v.e_cs = e_cs; v.e_we = e_we; v.e_addr = e_addr;
        v.e_di = e_di; v.e_byte = e_byte; v.e_sbusy = e_sbusy; v.e_rv = e_rv;
        vecs.push_back(v);
    endtask

    function automatic int rr_pick(input int from, input logic [1:0] cs);
        for (int k = 1; k <= 2; k++) begin
            if (((cs >> ((from + k) % 2)) & 2'b01) != 2'b00) return (from + k) % 2;
        end
        return from;
    endfunction

    localparam logic [31:0] D  = 32'h1111_1111;
    localparam logic [3:0]  B  = 4'hC;
    localparam logic [31:0] W  = 32'hA5A5_A5A5;

    initial begin
        // cs    we     a0        a1     d1 b1    busy mdo           | cs we addr     di  byte    sbusy  rv
        add_vec(2'b01, 2'b00, 32'h100, 32'h20, D, B, 1'b0, 32'h0,        1, 0, 32'h100, 0, 4'hF, 2'b00, 2'b00);
        add_vec(2'b00, 2'b00, 32'h100, 32'h20, D, B, 1'b0, 32'hDEADBEEF, 0, 0, 32'h0,   0, 4'h0, 2'b00, 2'b01);
        add_vec(2'b11, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'h0,        1, 0, 32'h20,  D, B,    2'b01, 2'b00);
        add_vec(2'b11, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'hCAFE0001, 1, 0, 32'h10,  0, 4'hF, 2'b10, 2'b10);
        add_vec(2'b11, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'hCAFE0002, 1, 0, 32'h20,  D, B,    2'b01, 2'b01);
        add_vec(2'b11, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'hCAFE0003, 1, 0, 32'h10,  0, 4'hF, 2'b10, 2'b10);
        add_vec(2'b11, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'hCAFE0004, 1, 0, 32'h20,  D, B,    2'b01, 2'b01);
        add_vec(2'b11, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'hCAFE0005, 1, 0, 32'h10,  0, 4'hF, 2'b10, 2'b10);
        add_vec(2'b11, 2'b10, 32'h10,  32'h20, W, 4'h3, 1'b1, 32'h0,     1, 1, 32'h20,  W, 4'h3, 2'b11, 2'b01);
        add_vec(2'b11, 2'b10, 32'h10,  32'h20, W, 4'h3, 1'b1, 32'h0,     1, 1, 32'h20,  W, 4'h3, 2'b11, 2'b00);
        add_vec(2'b11, 2'b10, 32'h10,  32'h20, W, 4'h3, 1'b1, 32'h0,     1, 1, 32'h20,  W, 4'h3, 2'b11, 2'b00);
        add_vec(2'b11, 2'b10, 32'h10,  32'h20, W, 4'h3, 1'b0, 32'h0,     1, 1, 32'h20,  W, 4'h3, 2'b01, 2'b00);
        add_vec(2'b01, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'h0,        1, 0, 32'h10,  0, 4'hF, 2'b00, 2'b00);
        add_vec(2'b00, 2'b11, 32'h10,  32'h20, D, B, 1'b0, 32'h5555AAAA, 0, 0, 32'h0,   0, 4'h0, 2'b00, 2'b01);
        add_vec(2'b01, 2'b00, 32'h10,  32'h20, D, B, 1'b1, 32'h0,        1, 0, 32'h10,  0, 4'hF, 2'b01, 2'b00);
        add_vec(2'b11, 2'b00, 32'h10,  32'h20, D, B, 1'b1, 32'h0,        1, 0, 32'h10,  0, 4'hF, 2'b11, 2'b00);
        add_vec(2'b11, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'h0,        1, 0, 32'h10,  0, 4'hF, 2'b10, 2'b00);
        add_vec(2'b10, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'h0,        1, 0, 32'h20,  D, B,    2'b00, 2'b01);
        add_vec(2'b00, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'h12345678, 0, 0, 32'h0,   0, 4'h0, 2'b00, 2'b10);
        add_vec(2'b10, 2'b00, 32'h10,  32'h20, D, B, 1'b1, 32'h0,        1, 0, 32'h20,  D, B,    2'b10, 2'b00);
        add_vec(2'b01, 2'b00, 32'h10,  32'h20, D, B, 1'b1, 32'h0,        1, 0, 32'h10,  0, 4'hF, 2'b01, 2'b00);
        add_vec(2'b01, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'h0,        1, 0, 32'h10,  0, 4'hF, 2'b00, 2'b00);
        add_vec(2'b00, 2'b00, 32'h10,  32'h20, D, B, 1'b0, 32'h0BADF00D, 0, 0, 32'h0,   0, 4'h0, 2'b00, 2'b01);

        rstn = 1'b0;
        apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        check_vec("reset", 0, 0, 32'h0, 32'h0, 4'h0, 2'b00, 2'b00, 32'h0);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i].cs, vecs[i].we, vecs[i].a0, vecs[i].a1, 32'h0, vecs[i].d1,
                           4'hF, vecs[i].b1, vecs[i].busy, vecs[i].mdo);
            #1;
            check_vec($sformatf("vec%0d", i), vecs[i].e_cs, vecs[i].e_we, vecs[i].e_addr,
                      vecs[i].e_di, vecs[i].e_byte, vecs[i].e_sbusy, vecs[i].e_rv, vecs[i].mdo);
        end

        // Reset lands the cycle after a read accept from requester 0.
        @(negedge clk);
        apply_stimulus(2'b01, 2'b00, 32'h10, 32'h20, 0, D, 4'hF, B, 1'b0, 32'h0);
        @(negedge clk);
        rstn = 1'b0;
        apply_stimulus(2'b00, 2'b00, 32'h10, 32'h20, 0, D, 4'hF, B, 1'b0, 32'h77);
        #1;
        check_output("rst_mid.s_rvalid", 64'(s_rvalid), 64'(2'b00));
        check_output("rst_mid.m_cs", 64'(m_cs), 64'(1'b0));
        @(negedge clk);
        rstn = 1'b1;
        apply_stimulus(2'b11, 2'b00, 32'h10, 32'h20, 0, D, 4'hF, B, 1'b0, 32'h0);
        #1;
        check_output("rst_after.m_addr", 64'(m_addr), 64'(32'h10));
        check_output("rst_after.s_busy", 64'(s_busy), 64'(2'b10));
        check_output("rst_after.s_rvalid", 64'(s_rvalid), 64'(2'b00));

        // Randomized traffic against the reference model, from a fresh reset.
        @(negedge clk);
        rstn = 1'b0;
        apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        begin
            int          last = 1;
            bit          held = 0;
            int          held_idx = 0;
            bit          pend = 0;
            int          owner = 0;
            int          g;
            logic [1:0]  rcs, rwe;
            logic [31:0] a0, a1, d0, d1, mdo;
            logic [3:0]  b0, b1;
            logic        busy, req, e_we;
            logic [31:0] e_addr, e_di;
            logic [3:0]  e_byte;
            logic [1:0]  e_sb, e_rv;
            for (int n = 0; n < 300; n++) begin
                @(negedge clk);
                rcs  = 2'($urandom_range(0, 3));
                rwe  = 2'($urandom_range(0, 3));
                a0   = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
                b0   = 4'($urandom); b1 = 4'($urandom);
                busy = ($urandom_range(0, 9) < 3);
                mdo  = $urandom;
                apply_stimulus(rcs, rwe, a0, a1, d0, d1, b0, b1, busy, mdo);

                req = (rcs != 2'b00);
                if (held && (((rcs >> held_idx) & 2'b01) != 2'b00)) g = held_idx;
                else g = rr_pick(last, rcs);
                e_we   = req && (((rwe >> g) & 2'b01) != 2'b00);
                e_addr = !req ? 32'h0 : (g == 0) ? a0 : a1;
                e_di   = !req ? 32'h0 : (g == 0) ? d0 : d1;
                e_byte = !req ? 4'h0  : (g == 0) ? b0 : b1;
                e_sb   = busy ? rcs : (rcs & ~(2'b01 << g));
                e_rv   = pend ? (2'b01 << owner) : 2'b00;
                #1;
                check_vec($sformatf("rand%0d", n), req, e_we, e_addr, e_di, e_byte, e_sb, e_rv, mdo);

                held     = req && busy;
                held_idx = g;
                pend     = req && !busy && !e_we;
                owner    = g;
                if (req && !busy) last = g;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
